// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the RV32I multicycle control FSM
//
// Purpose: FSM state enum, RV32I opcode constants, ALU operation codes
//          (shared with the ALU), operand/result select codes and the
//          ALU-decode class used by alu_op_decoder.
// Ports:   none (package).

package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXECR    = 4'd2,
    S_EXECI    = 4'd3,
    S_LUI      = 4'd4,
    S_ALUWB    = 4'd5,
    S_MEMADR   = 4'd6,
    S_MEMREAD  = 4'd7,
    S_MEMWB    = 4'd8,
    S_MEMWRITE = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALR_PC  = 4'd13,
    S_HALT     = 4'd14
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_OR  = 4'h2,
    ALU_SLL = 4'h3,
    ALU_SRL = 4'h4,
    ALU_LUI = 4'h5,
    ALU_AND = 4'h6,
    ALU_XOR = 4'h7,
    ALU_BEQ = 4'h8,
    ALU_BNE = 4'h9,
    ALU_BLT = 4'hA,
    ALU_BGE = 4'hB
  } alu_op_e;

  // Which decode table the current state asks the ALU decoder to use.
  typedef enum logic [2:0] {
    CLS_ADD = 3'd0,
    CLS_R   = 3'd1,
    CLS_I   = 3'd2,
    CLS_BR  = 3'd3,
    CLS_LUI = 3'd4
  } alu_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/datapath bundle between the FSM and the shared datapath
//
// Purpose: groups the instruction fields, ALU Zero flag, memory handshake and
//          every datapath control output of multicycle_ctrl.
// Modports:
//   master - the control FSM: reads IR fields, zero_i, mem_ack_i; drives all *_o
//   slave  - the datapath/memory side: the reverse

interface multicycle_ctrl_if;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic       funct7_5_i;
  logic       zero_i;
  logic       mem_ack_i;
  logic [3:0] alu_operation_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] result_src_o;
  logic       iord_o;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       pc_write_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic       illegal_o;

  modport master (
    input  opcode_i, funct3_i, funct7_5_i, zero_i, mem_ack_i,
    output alu_operation_o, alu_src_a_o, alu_src_b_o, result_src_o,
           iord_o, mem_req_o, mem_we_o, pc_write_o, ir_write_o,
           reg_write_o, illegal_o
  );

  modport slave (
    output opcode_i, funct3_i, funct7_5_i, zero_i, mem_ack_i,
    input  alu_operation_o, alu_src_a_o, alu_src_b_o, result_src_o,
           iord_o, mem_req_o, mem_we_o, pc_write_o, ir_write_o,
           reg_write_o, illegal_o
  );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decoder.sv
// rtl/multicycle_ctrl_alu_op_decoder.sv - combinational ALU operation decode
//
// Purpose: maps (decode class, funct3, funct7_5) to the 4-bit ALU operation
//          and flags funct3 values the class does not support.
// Ports:
//   alu_class     in   decode table selected by the FSM state
//   funct3        in   IR[14:12]
//   funct7_5      in   IR[30]
//   alu_operation out  ALU operation code (ADD when illegal)
//   illegal       out  funct3 not supported for this class

module alu_op_decoder
  import multicycle_pkg::*;
(
  input  alu_class_e alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_operation,
  output logic       illegal
);

  always_comb begin
    alu_operation = ALU_ADD;
    illegal       = 1'b0;
    case (alu_class)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  alu_operation = (alu_class == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_operation = ALU_SLL;
          3'b100:  alu_operation = ALU_XOR;
          3'b101:  alu_operation = ALU_SRL;
          3'b110:  alu_operation = ALU_OR;
          3'b111:  alu_operation = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      CLS_BR: begin
        case (funct3)
          3'b000:  alu_operation = ALU_BEQ;
          3'b001:  alu_operation = ALU_BNE;
          3'b100:  alu_operation = ALU_BLT;
          3'b101:  alu_operation = ALU_BGE;
          default: illegal = 1'b1;
        endcase
      end
      CLS_LUI: alu_operation = ALU_LUI;
      default: alu_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control FSM for the RV32I datapath
//
// Purpose: Moore FSM (FETCH/DECODE/EXEC/MEM/WB/BRANCH/JAL/JALR) driving ALU
//          operation, operand selects and datapath write enables; memory is
//          accessed through a req/ack handshake.
// Ports:
//   clk_i    in  system clock, rising edge
//   rst_n_i  in  synchronous active-low reset
//   bus      multicycle_ctrl_if.master: IR fields, zero_i, mem_ack_i in;
//            alu_operation_o, selects, enables, mem_req_o/mem_we_o, illegal_o out
// Configuration:
//   ILLEGAL_TRAP_EN defined   - illegal instruction enters HALT (illegal_o=1)
//                               until reset
//   ILLEGAL_TRAP_EN undefined - illegal instruction is a NOP, illegal_o tied 0

module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  multicycle_ctrl_if.master  bus
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e ILL_NEXT = S_HALT;
`else
  localparam state_e ILL_NEXT = S_FETCH;
`endif

  state_e     state_q, state_d;
  logic       run_q;
  logic       active;

  alu_class_e alu_class;
  alu_op_e    dec_op;
  logic       dec_ill;

  logic [3:0] op;
  logic [1:0] src_a, src_b, res_src;
  logic       iord, mem_req, mem_we, pc_write, ir_write, reg_write, illegal;

  // run_q keeps the FSM quiet for the cycle in which reset is released, so the
  // first request appears in the cycle after rst_n_i rises and an ack left
  // over from an aborted access cannot be mistaken for a fetch completion.
  assign active = rst_n_i & run_q;

  always_ff @(posedge clk_i) begin
    run_q <= rst_n_i;
    if (!active) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  alu_op_decoder u_alu_op_decoder (
    .alu_class     (alu_class),
    .funct3        (bus.funct3_i),
    .funct7_5      (bus.funct7_5_i),
    .alu_operation (dec_op),
    .illegal       (dec_ill)
  );

  always_comb begin
    state_d   = state_q;
    alu_class = CLS_ADD;
    op        = ALU_ADD;
    src_a     = SRC_A_PC;
    src_b     = SRC_B_RS2;
    res_src   = RES_ALUOUT;
    iord      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        src_a   = SRC_A_PC;
        src_b   = SRC_B_FOUR;
        res_src = RES_ALU;
        mem_req = 1'b1;
        if (bus.mem_ack_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      // ALUOut captures oldPC + imm here: the branch/JAL target.
      S_DECODE: begin
        src_a = SRC_A_OLDPC;
        src_b = SRC_B_IMM;
        case (bus.opcode_i)
          OP_R:      state_d = S_EXECR;
          OP_I:      state_d = S_EXECI;
          OP_LOAD:   state_d = S_MEMADR;
          OP_STORE:  state_d = S_MEMADR;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = ILL_NEXT;
        endcase
      end

      S_EXECR: begin
        alu_class = CLS_R;
        src_a     = SRC_A_RS1;
        src_b     = SRC_B_RS2;
        op        = dec_op;
        state_d   = dec_ill ? ILL_NEXT : S_ALUWB;
      end

      S_EXECI: begin
        alu_class = CLS_I;
        src_a     = SRC_A_RS1;
        src_b     = SRC_B_IMM;
        op        = dec_op;
        state_d   = dec_ill ? ILL_NEXT : S_ALUWB;
      end

      S_LUI: begin
        alu_class = CLS_LUI;
        src_b     = SRC_B_IMM;
        op        = dec_op;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        res_src   = RES_ALUOUT;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEMADR: begin
        src_a   = SRC_A_RS1;
        src_b   = SRC_B_IMM;
        state_d = (bus.opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ack_i) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        res_src   = RES_DATA;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ack_i) begin
          state_d = S_FETCH;
        end
      end

      // The ALU reports "condition holds" as a non-zero result, so a taken
      // branch shows up as zero_i=0. PC loads the target already in ALUOut.
      S_BRANCH: begin
        alu_class = CLS_BR;
        src_a     = SRC_A_RS1;
        src_b     = SRC_B_RS2;
        res_src   = RES_ALUOUT;
        op        = dec_op;
        pc_write  = !bus.zero_i && !dec_ill;
        state_d   = dec_ill ? ILL_NEXT : S_FETCH;
      end

      // PC <- ALUOut (target) while the ALU forms oldPC + 4 for the link.
      S_JAL, S_JALR_PC: begin
        src_a    = SRC_A_OLDPC;
        src_b    = SRC_B_FOUR;
        res_src  = RES_ALUOUT;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end

      S_JALR: begin
        src_a   = SRC_A_RS1;
        src_b   = SRC_B_IMM;
        state_d = S_JALR_PC;
      end

      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        illegal = 1'b1;
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase

    if (!active) begin
      op        = 4'h0;
      src_a     = 2'b00;
      src_b     = 2'b00;
      res_src   = 2'b00;
      iord      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign bus.alu_operation_o = op;
  assign bus.alu_src_a_o     = src_a;
  assign bus.alu_src_b_o     = src_b;
  assign bus.result_src_o    = res_src;
  assign bus.iord_o          = iord;
  assign bus.mem_req_o       = mem_req;
  assign bus.mem_we_o        = mem_we;
  assign bus.pc_write_o      = pc_write;
  assign bus.ir_write_o      = ir_write;
  assign bus.reg_write_o     = reg_write;
  assign bus.illegal_o       = illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

  logic clk_i = 1'b0;
  logic rst_n_i;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  // {op, src_a, src_b, result, iord, req, we, pc_write, ir_write, reg_write, illegal}
  logic [16:0] obs;
  assign obs = {bus.alu_operation_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.result_src_o,
                bus.iord_o, bus.mem_req_o, bus.mem_we_o, bus.pc_write_o,
                bus.ir_write_o, bus.reg_write_o, bus.illegal_o};

  localparam logic [16:0] E_IDLE      = 17'h0;
  localparam logic [16:0] E_FETCH     = {4'h0, 2'b00, 2'b10, 2'b10, 7'b0100000};
  localparam logic [16:0] E_FETCH_ACK = {4'h0, 2'b00, 2'b10, 2'b10, 7'b0101100};
  localparam logic [16:0] E_DECODE    = {4'h0, 2'b01, 2'b01, 2'b00, 7'b0000000};
  localparam logic [16:0] E_ALUWB     = {4'h0, 2'b00, 2'b00, 2'b00, 7'b0000010};
  localparam logic [16:0] E_MEMADR    = {4'h0, 2'b10, 2'b01, 2'b00, 7'b0000000};
  localparam logic [16:0] E_MEMREAD   = {4'h0, 2'b00, 2'b00, 2'b00, 7'b1100000};
  localparam logic [16:0] E_MEMWRITE  = {4'h0, 2'b00, 2'b00, 2'b00, 7'b1110000};
  localparam logic [16:0] E_MEMWB     = {4'h0, 2'b00, 2'b00, 2'b01, 7'b0000010};
  localparam logic [16:0] E_JALPC     = {4'h0, 2'b01, 2'b10, 2'b00, 7'b0001000};
  localparam logic [16:0] E_LUI       = {4'h5, 2'b00, 2'b01, 2'b00, 7'b0000000};
  localparam logic [16:0] E_HALT      = {4'h0, 2'b00, 2'b00, 2'b00, 7'b0000001};

  function automatic logic [16:0] e_exec(input logic [3:0] op, input logic [1:0] sb);
    return {op, 2'b10, sb, 2'b00, 7'b0000000};
  endfunction

  function automatic logic [16:0] e_branch(input logic [3:0] op, input logic pcw);
    return {op, 2'b10, 2'b00, 2'b00, 3'b000, pcw, 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ack, input logic z);
    @(posedge clk_i);
    #1;
    bus.mem_ack_i = ack;
    bus.zero_i    = z;
    #1;
  endtask

  task automatic set_ir(input logic [6:0] opc, input logic [2:0] f3, input logic f75);
    bus.opcode_i   = opc;
    bus.funct3_i   = f3;
    bus.funct7_5_i = f75;
  endtask

  initial begin
    rst_n_i        = 1'b0;
    bus.mem_ack_i  = 1'b0;
    bus.zero_i     = 1'b0;
    set_ir(7'h00, 3'd0, 1'b0);

    step(0, 0); chk("reset_idle", E_IDLE);
    step(1, 0); chk("reset_ack_ignored", E_IDLE);
    rst_n_i = 1'b1;
    #1 chk("rst_rise_quiet", E_IDLE);

    // add x3,x1,x2 (0x002081B3)
    set_ir(7'b0110011, 3'b000, 1'b0);
    step(1, 0); chk("add_fetch", E_FETCH_ACK);
    step(0, 0); chk("add_decode", E_DECODE);
    step(0, 0); chk("add_execr", e_exec(4'h0, 2'b00));
    step(0, 0); chk("add_aluwb", E_ALUWB);

    set_ir(7'b0110011, 3'b000, 1'b1);
    step(1, 0); chk("sub_fetch", E_FETCH_ACK);
    step(0, 0); chk("sub_decode", E_DECODE);
    step(0, 0); chk("sub_execr", e_exec(4'h1, 2'b00));
    step(0, 0); chk("sub_aluwb", E_ALUWB);

    set_ir(7'b0010011, 3'b000, 1'b1);
    step(1, 0); chk("addi_fetch", E_FETCH_ACK);
    step(0, 0); chk("addi_decode", E_DECODE);
    step(0, 0); chk("addi_execi", e_exec(4'h0, 2'b01));
    step(0, 0); chk("addi_aluwb", E_ALUWB);

    set_ir(7'b0010011, 3'b101, 1'b1);
    step(1, 0); chk("srli_fetch", E_FETCH_ACK);
    step(0, 0); chk("srli_decode", E_DECODE);
    step(0, 0); chk("srli_execi", e_exec(4'h4, 2'b01));
    step(0, 0); chk("srli_aluwb", E_ALUWB);

    set_ir(7'b1100011, 3'b000, 1'b0);
    step(1, 0); chk("beq_t_fetch", E_FETCH_ACK);
    step(0, 0); chk("beq_t_decode", E_DECODE);
    step(0, 0); chk("beq_taken", e_branch(4'h8, 1'b1));
    step(1, 0); chk("beq_nt_fetch", E_FETCH_ACK);
    step(0, 0); chk("beq_nt_decode", E_DECODE);
    step(0, 1); chk("beq_not_taken", e_branch(4'h8, 1'b0));

    set_ir(7'b1100011, 3'b101, 1'b0);
    step(1, 0); chk("bge_fetch", E_FETCH_ACK);
    step(0, 0); chk("bge_decode", E_DECODE);
    step(0, 0); chk("bge_taken", e_branch(4'hB, 1'b1));

    // lw with one fetch wait and two MEMREAD wait cycles
    set_ir(7'b0000011, 3'b010, 1'b0);
    step(0, 0); chk("lw_fetch_wait", E_FETCH);
    step(1, 0); chk("lw_fetch", E_FETCH_ACK);
    step(0, 0); chk("lw_decode", E_DECODE);
    step(0, 0); chk("lw_memadr", E_MEMADR);
    step(0, 0); chk("lw_memread_w1", E_MEMREAD);
    step(0, 0); chk("lw_memread_w2", E_MEMREAD);
    step(1, 0); chk("lw_memread_ack", E_MEMREAD);
    step(0, 0); chk("lw_memwb", E_MEMWB);

    set_ir(7'b1100111, 3'b000, 1'b0);
    step(1, 0); chk("jalr_fetch", E_FETCH_ACK);
    step(0, 0); chk("jalr_decode", E_DECODE);
    step(0, 0); chk("jalr_target", E_MEMADR);
    step(0, 0); chk("jalr_pc", E_JALPC);
    step(0, 0); chk("jalr_link", E_ALUWB);

    set_ir(7'b1101111, 3'b000, 1'b0);
    step(1, 0); chk("jal_fetch", E_FETCH_ACK);
    step(0, 0); chk("jal_decode", E_DECODE);
    step(0, 0); chk("jal_pc", E_JALPC);
    step(0, 0); chk("jal_link", E_ALUWB);

    set_ir(7'b0110111, 3'b000, 1'b0);
    step(1, 0); chk("lui_fetch", E_FETCH_ACK);
    step(0, 0); chk("lui_decode", E_DECODE);
    step(0, 0); chk("lui_exec", E_LUI);
    step(0, 0); chk("lui_aluwb", E_ALUWB);

    // sw aborted by reset during the MEMWRITE wait, then a late ack
    set_ir(7'b0100011, 3'b010, 1'b0);
    step(1, 0); chk("sw_fetch", E_FETCH_ACK);
    step(0, 0); chk("sw_decode", E_DECODE);
    step(0, 0); chk("sw_memadr", E_MEMADR);
    step(0, 0); chk("sw_memwrite_wait", E_MEMWRITE);
    @(posedge clk_i);
    #1 rst_n_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    #1 chk("sw_rst_low", E_IDLE);
    step(1, 0); chk("sw_rst_held", E_IDLE);
    rst_n_i = 1'b1;
    #1 chk("sw_late_ack", E_IDLE);
    step(0, 0); chk("post_rst_fetch", E_FETCH);

    // branch with unsupported funct3
    set_ir(7'b1100011, 3'b010, 1'b0);
    step(1, 0); chk("bill_fetch", E_FETCH_ACK);
    step(0, 0); chk("bill_decode", E_DECODE);
    step(0, 0); chk("bill_branch", e_branch(4'h0, 1'b0));
`ifdef ILLEGAL_TRAP_EN
    step(1, 0); chk("bill_halt", E_HALT);
    step(1, 0); chk("bill_halt_hold", E_HALT);
    rst_n_i = 1'b0;
    step(0, 0); chk("halt_rst", E_IDLE);
    rst_n_i = 1'b1;
    #1 chk("halt_rst_rise", E_IDLE);
    step(0, 0); chk("halt_refetch", E_FETCH);
`else
    step(0, 0); chk("bill_nop_fetch", E_FETCH);
`endif

    // illegal opcode 0x7F
    set_ir(7'h7F, 3'b000, 1'b0);
    step(1, 0); chk("ill_fetch", E_FETCH_ACK);
    step(0, 0); chk("ill_decode", E_DECODE);
`ifdef ILLEGAL_TRAP_EN
    step(1, 0); chk("ill_halt", E_HALT);
    step(1, 0); chk("ill_halt_hold", E_HALT);
`else
    step(0, 0); chk("ill_nop_fetch", E_FETCH);
    step(0, 0); chk("ill_fetch_hold", E_FETCH);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I datapath, and the initiating end of the ALU operation interface. Each state drives the 4-bit ALU operation code, operand selects and datapath write enables, and each branch state reads back the ALU Zero flag. Memory accesses use a req/ack handshake. The block sits between the instruction register fields and the shared datapath (PC, IR, A/B, ALUOut and data registers).

## Interface
- No parameters. All encodings are fixed in the package.
- clk_i  in  1  system clock; rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- opcode_i  in  7  IR[6:0]
- funct3_i  in  3  IR[14:12]
- funct7_5_i  in  1  IR[30]
- zero_i  in  1  ALU Zero flag
- mem_ack_i  in  1  memory completes the access this cycle
- alu_operation_o  out  4  ADD 0, SUB 1, OR 2, SLL 3, SRL 4, LUI 5, AND 6, XOR 7, BEQ 8, BNE 9, BLT A, BGE B
- alu_src_a_o  out  2  00 PC, 01 oldPC, 10 A register (rs1)
- alu_src_b_o  out  2  00 B register (rs2), 01 immediate, 10 constant 4
- result_src_o  out  2  00 ALUOut, 01 data register, 10 ALU result direct
- iord_o  out  1  memory address select: 0 PC, 1 ALUOut
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write qualifier
- pc_write_o, ir_write_o, reg_write_o  out  1 each  datapath register enables
- illegal_o  out  1  illegal instruction flag

## Operation
- Moore FSM. Outputs are decoded from a registered state. Exception: pc_write_o depends on zero_i in BRANCH and on mem_ack_i in FETCH.
- FETCH: mem_req=1, iord=0, src_a=PC, src_b=4, op=ADD, result=10. Hold the state until mem_ack_i is high. In the ack cycle, ir_write=1 and pc_write=1; next state is DECODE.
- DECODE: src_a=oldPC, src_b=imm, op=ADD, so ALUOut gets the branch/JAL target. Dispatch on opcode:
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0000011 / 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
- EXECR: src_a=rs1, src_b=rs2. Operation from funct3:
  - 000: SUB if funct7_5=1, else ADD
  - 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND
  - next state ALUWB
- EXECI: same decode with src_b=imm, and funct3 000 is always ADD. Next state ALUWB.
- LUI: src_b=imm, op=LUI. Next state ALUWB.
- ALUWB: result=00, reg_write=1. Next state FETCH.
- MEMADR: src_a=rs1, src_b=imm, op=ADD. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, iord=1. Hold until ack, then go to MEMWB.
- MEMWB: result=01, reg_write=1. Next state FETCH.
- MEMWRITE: mem_req=1, mem_we=1, iord=1. Hold until ack, then go to FETCH.
- BRANCH: src_a=rs1, src_b=rs2, result=00. funct3 selects the op: 000 BEQ, 001 BNE, 100 BLT, 101 BGE. The ALU returns 1 when the condition holds, so the branch is taken when zero_i=0 and pc_write is driven as !zero_i. Next state FETCH.
- JAL: src_a=oldPC, src_b=4, op=ADD, result=00, pc_write=1. ALUOut then holds the link value. Next state ALUWB.
- JALR: src_a=rs1, src_b=imm, op=ADD (target into ALUOut). Next state JALR_PC.
- JALR_PC: behaves exactly as the JAL state, then goes to ALUWB. This is safe when rd=rs1 because the A register was already latched.
- Illegal instruction: an unlisted opcode, or an unlisted funct3 in EXECR/EXECI/BRANCH. Handling is set by the macro in Configuration.
- Unused control fields read 0.

## Timing
- Cycles per instruction with zero-wait memory:
  - BRANCH: 3
  - R/I-type, LUI, SW, JAL: 4
  - LW, JALR: 5
- Each memory wait cycle adds one cycle. No write enable is asserted in a cycle without mem_ack_i.
- mem_req_o stays high continuously from entry to FETCH/MEMREAD/MEMWRITE until the ack cycle, inclusive.
- Reset while rst_n_i is low:
  - state→FETCH on the clock edge
  - all enables, mem_req_o, mem_we_o and illegal_o are forced to 0
  - selects and alu_operation_o are forced to 0
- First request after reset: the cycle after rst_n_i rises.
- Reset mid-operation (including mid-handshake) aborts the instruction. No register or memory write is issued, and a late mem_ack_i is ignored.

## Configuration
- ILLEGAL_TRAP_EN defined: an illegal instruction enters HALT.
  - illegal_o=1, all enables 0
  - HALT holds until reset
- ILLEGAL_TRAP_EN undefined: an illegal instruction is a NOP.
  - DECODE (or the EXEC state) returns to FETCH with no writes
  - the PC is already advanced
  - illegal_o is tied to 0

## Structure
- Package multicycle_pkg holds:
  - the state enum
  - opcode constants
  - ALU operation codes, shared with the ALU
  - src_a/src_b/result select codes
- Sub-module alu_op_decoder: combinational (state class, funct3, funct7_5) → alu_operation, plus an illegal flag.

## Test plan
- Reset, zero-wait memory, IR=add (0x002081B3): exact sequence FETCH, DECODE, EXECR, ALUWB, with op=0 in EXECR and reg_write=1 only in cycle 4.
- sub (funct7_5=1, funct3=000) → op=1. addi funct3=000 with funct7_5=1 → op=0.
- beq with zero_i=0 → pc_write=1 in BRANCH. Same instruction with zero_i=1 → pc_write=0. op=8. Total 3 cycles.
- lw with mem_ack_i delayed 2 cycles in MEMREAD → mem_req held 3 cycles, reg_write in MEMWB, 7 cycles total.
- jalr: target in JALR, PC write in JALR_PC, link write in ALUWB, 5 cycles.
- rst_n_i low during MEMWRITE wait → mem_we_o=0 next cycle, state FETCH. Opcode 0x7F → illegal_o=1 and stuck in HALT (trap enabled), or back in FETCH after 2 cycles (trap disabled).
